// File: rtl/ysyx_25040109_sram.sv
// rtl/ysyx_25040109_sram.sv - single-beat AXI4-lite-style word memory responder with fixed read/write latency
// Independent read and write FSMs share one word array; reads sample with NBA semantics so a same-edge write is not seen.
module ysyx_25040109_sram #(
   parameter int                 ADDR_W     = 32,
   parameter int                 DEPTH_LOG2 = 12,
   parameter logic [ADDR_W-1:0]  BASE       = 'h8000_0000,
   parameter int                 RD_LAT     = 1,
   parameter int                 WR_LAT     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   input  logic [3:0]        arid,
   output logic              arready,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic [3:0]        rid,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   input  logic [3:0]        awid,
   output logic              awready,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic              bvalid,
   input  logic              bready,
   output logic [1:0]        bresp,
   output logic [3:0]        bid
);

   localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
   localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

   // ---------------- read channel ----------------
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   r_state_t r_state, r_next;

   logic [3:0]            r_cnt;
   logic [ADDR_W-1:0]     r_addr;
   logic [ADDR_W-1:0]     r_off;
   logic                  r_in;
   logic [DEPTH_LOG2-1:0] r_idx;

   assign r_off = r_addr - BASE;
   assign r_in  = (r_off[ADDR_W-1:DEPTH_LOG2+2] == '0);
   assign r_idx = r_off[DEPTH_LOG2+1:2];

   assign arready = (r_state == R_IDLE);
   assign rvalid  = (r_state == R_RESP);
   assign rlast   = rvalid;

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (arvalid)      r_next = R_WAIT;
         R_WAIT:  if (r_cnt == '0)  r_next = R_RESP;
         R_RESP:  if (rready)       r_next = R_IDLE;
         default:                   r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= R_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         rid     <= '0;
         rdata   <= '0;
         rresp   <= OKAY;
      end else begin
         r_state <= r_next;
         if (r_state == R_IDLE && arvalid) begin
            r_addr <= araddr;
            rid    <= arid;
            r_cnt  <= RD_CNT;
         end
         if (r_state == R_WAIT) begin
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - 4'd1;
            end else begin
               rdata <= r_in ? mem[r_idx] : 32'h0;
               rresp <= r_in ? OKAY : SLVERR;
            end
         end
      end
   end

   // ---------------- write channel ----------------
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
   w_state_t w_state, w_next;

   logic [3:0]            w_cnt;
   logic                  aw_got, w_got;
   logic                  aw_hs, w_hs, both;
   logic [ADDR_W-1:0]     w_addr;
   logic [31:0]           w_data;
   logic [3:0]            w_strb;
   logic [ADDR_W-1:0]     w_off;
   logic                  w_in;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  commit;

   assign w_off = w_addr - BASE;
   assign w_in  = (w_off[ADDR_W-1:DEPTH_LOG2+2] == '0);
   assign w_idx = w_off[DEPTH_LOG2+1:2];

   assign awready = (w_state == W_IDLE) && !aw_got;
   assign wready  = (w_state == W_IDLE) && !w_got;
   assign bvalid  = (w_state == W_RESP);
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign both    = (aw_got || aw_hs) && (w_got || w_hs);
   assign commit  = (w_state == W_WAIT) && (w_cnt == '0) && w_in;

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (both)         w_next = W_WAIT;
         W_WAIT:  if (w_cnt == '0)  w_next = W_RESP;
         W_RESP:  if (bready)       w_next = W_IDLE;
         default:                   w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state <= W_IDLE;
         w_cnt   <= '0;
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         w_addr  <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         bid     <= '0;
         bresp   <= OKAY;
      end else begin
         w_state <= w_next;
         if (aw_hs) begin
            w_addr <= awaddr;
            bid    <= awid;
            aw_got <= 1'b1;
         end
         if (w_hs) begin
            w_data <= wdata;
            w_strb <= wstrb;
            w_got  <= 1'b1;
         end
         if (w_state == W_IDLE && both) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            w_cnt  <= WR_CNT;
         end
         if (w_state == W_WAIT) begin
            if (w_cnt != '0) begin
               w_cnt <= w_cnt - 4'd1;
            end else begin
               bresp <= w_in ? OKAY : SLVERR;
            end
         end
      end
   end

   // Storage has no reset; rst still blocks a commit landing on a reset edge.
   always_ff @(posedge clk) begin
      if (!rst && commit) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, wlast, r_off[1:0], w_off[1:0]};

endmodule

// File: tb/tb_ysyx_25040109_sram.sv
// tb/tb_ysyx_25040109_sram.sv - directed self-checking bench for ysyx_25040109_sram
module tb_ysyx_25040109_sram;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // main instance: RD_LAT=1, WR_LAT=1
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]  arid, rid, awid, wstrb, bid;
   logic [1:0]  rresp, bresp;

   // second instance: RD_LAT=3, read channel only exercised
   logic [31:0] araddr3, rdata3;
   logic        arvalid3, arready3, rlast3, rvalid3, rready3;
   logic [3:0]  arid3, rid3, bid3;
   logic [1:0]  rresp3, bresp3;
   logic        awready3, wready3, bvalid3;

   int checks = 0;
   int errors = 0;

   ysyx_25040109_sram #(.RD_LAT(1), .WR_LAT(1)) u_dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arid(arid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
   );

   ysyx_25040109_sram #(.RD_LAT(3), .WR_LAT(2)) u_dut3 (
      .clk(clk), .rst(rst),
      .araddr(araddr3), .arvalid(arvalid3), .arid(arid3), .arready(arready3),
      .rdata(rdata3), .rresp(rresp3), .rid(rid3), .rlast(rlast3), .rvalid(rvalid3), .rready(rready3),
      .awaddr(32'h0), .awvalid(1'b0), .awid(4'h0), .awready(awready3),
      .wdata(32'h0), .wstrb(4'h0), .wlast(1'b0), .wvalid(1'b0), .wready(wready3),
      .bvalid(bvalid3), .bready(1'b1), .bresp(bresp3), .bid(bid3)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic rd1(input logic [31:0] a, input logic [3:0] id,
                      output logic [31:0] d, output logic [1:0] rs, output logic [3:0] ri,
                      output logic rl, output int lat);
      araddr = a; arid = id; arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
      d = rdata; rs = rresp; ri = rid; rl = rlast;
      @(posedge clk); #1;
   endtask

   task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [3:0] id, input int gap,
                      output logic [1:0] rdy, output logic [1:0] br, output logic [3:0] bi,
                      output int lat);
      awaddr = a; awid = id; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = (gap == 0);
      @(posedge clk); #1;
      awvalid = 1'b0;
      rdy = {awready, wready};
      if (gap > 0) begin
         repeat (gap - 1) begin @(posedge clk); #1; end
         wvalid = 1'b1;
         @(posedge clk); #1;
      end
      wvalid = 1'b0;
      lat = 0;
      while (!bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
      br = bresp; bi = bid;
      @(posedge clk); #1;
   endtask

   logic [31:0] d;
   logic [1:0]  rs, br, rdy;
   logic [3:0]  ri, bi;
   logic        rl, seen;
   int          lat;

   initial begin
      rst = 1'b1;
      araddr = '0; arvalid = 0; arid = '0; rready = 1'b1;
      awaddr = '0; awvalid = 0; awid = '0; wdata = '0; wstrb = '0; wlast = 1'b1; wvalid = 0; bready = 1'b1;
      araddr3 = '0; arvalid3 = 0; arid3 = '0; rready3 = 1'b0;
      u_dut.mem[0]  = 32'h0000_0413;
      u_dut.mem[4]  = 32'h1122_3344;
      u_dut.mem[8]  = 32'h0000_0001;
      u_dut.mem[12] = 32'hCAFE_F00D;
      u_dut3.mem[1] = 32'h5555_AAAA;
      #12;
      chk("rst_ready", {arready, awready, wready, rvalid, bvalid}, 5'b11100);
      chk("rst_data",  {rdata, rresp, rid, bresp, bid}, 44'h0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // basic read
      rd1(32'h8000_0000, 4'd3, d, rs, ri, rl, lat);
      chk("rd_lat", lat, 1);
      chk("rd_data", {d, rs, ri, rl}, {32'h0000_0413, 2'b00, 4'd3, 1'b1});

      // AW first, W two edges later, partial strobe
      wr1(32'h8000_0010, 32'hAABB_CCDD, 4'b0101, 4'd9, 2, rdy, br, bi, lat);
      chk("wr_ready_split", rdy, 2'b01);
      chk("wr_lat", lat, 1);
      chk("wr_resp", {br, bi}, {2'b00, 4'd9});
      rd1(32'h8000_0010, 4'd1, d, rs, ri, rl, lat);
      chk("wr_readback", {d, rs}, {32'h11BB_33DD, 2'b00});

      // out of range
      rd1(32'h7FFF_FFFC, 4'd2, d, rs, ri, rl, lat);
      chk("oob_rd", {d, rs, ri}, {32'h0, 2'b10, 4'd2});
      wr1(32'h8000_4000, 32'hDEAD_BEEF, 4'b1111, 4'd4, 0, rdy, br, bi, lat);
      chk("oob_wr", {br, bi}, {2'b10, 4'd4});
      rd1(32'h8000_0000, 4'd0, d, rs, ri, rl, lat);
      chk("oob_nowrite", d, 32'h0000_0413);

      // same-edge read sample and write commit
      araddr = 32'h8000_0020; arid = 4'd6; arvalid = 1'b1;
      awaddr = 32'h8000_0020; awid = 4'd7; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      chk("same_wait", {rvalid, bvalid}, 2'b00);
      @(posedge clk); #1;
      chk("same_resp", {rvalid, bvalid, rdata, bresp}, {1'b1, 1'b1, 32'h1, 2'b00});
      @(posedge clk); #1;
      rd1(32'h8000_0020, 4'd0, d, rs, ri, rl, lat);
      chk("same_after", d, 32'h2);

      // backpressure on RD_LAT=3 instance
      araddr3 = 32'h8000_0004; arid3 = 4'd7; arvalid3 = 1'b1;
      @(posedge clk); #1;
      arvalid3 = 1'b0;
      lat = 0;
      while (!rvalid3 && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("bp_lat", lat, 3);
      for (int i = 0; i < 5; i++) begin
         arvalid3 = 1'b1;
         chk("bp_hold", {rvalid3, arready3, rid3, rdata3}, {1'b1, 1'b0, 4'd7, 32'h5555_AAAA});
         @(posedge clk); #1;
      end
      arvalid3 = 1'b0;
      chk("bp_hold_last", {rvalid3, arready3}, 2'b10);
      rready3 = 1'b1;
      @(posedge clk); #1;
      rready3 = 1'b0;
      chk("bp_release", {rvalid3, arready3}, 2'b01);

      // asynchronous reset during R_WAIT and W_WAIT
      araddr = 32'h8000_0000; arid = 4'd8; arvalid = 1'b1;
      awaddr = 32'h8000_0030; awid = 4'd5; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_ready", {arready, awready, wready, rvalid, bvalid}, 5'b11100);
      chk("arst_data",  {rdata, rresp, rid, bresp, bid}, 44'h0);
      @(posedge clk); @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      repeat (4) begin @(posedge clk); #1; seen = seen | rvalid | bvalid; end
      chk("arst_no_resp", seen, 1'b0);
      rd1(32'h8000_0030, 4'd0, d, rs, ri, rl, lat);
      chk("arst_nowrite", d, 32'hCAFE_F00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
